// File: rtl/dm_sba_mem_responder.sv
// Responder for the debug system-bus req/gnt/r_valid protocol.
// It is backed by a word-organised byte-enable RAM and has programmable grant and response delays.
module dm_sba_mem_responder #(
    parameter int unsigned          BusWidth  = 32,
    parameter int unsigned          Depth     = 256,
    parameter logic [BusWidth-1:0]  BaseAddr  = '0,
    parameter int unsigned          GntDelay  = 0,
    parameter int unsigned          RespDelay = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_req_i,
    input  logic [BusWidth-1:0]   slave_add_i,
    input  logic                  slave_we_i,
    input  logic [BusWidth-1:0]   slave_wdata_i,
    input  logic [BusWidth/8-1:0] slave_be_i,
    output logic                  slave_gnt_o,
    output logic                  slave_r_valid_o,
    output logic [BusWidth-1:0]   slave_r_rdata_o,
    output logic                  slave_err_o
);

    localparam int unsigned NumBytes  = BusWidth / 8;
    localparam int unsigned ByteShift = $clog2(NumBytes);
    localparam int unsigned IdxW      = $clog2(Depth);
    localparam int unsigned CntW      = 16;

    localparam logic [CntW-1:0] GntLoad  = (GntDelay > 0) ? CntW'(GntDelay - 1) : '0;
    localparam logic [CntW-1:0] RespLoad = (RespDelay > 0) ? CntW'(RespDelay - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StGntWait,
        StResp
    } state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic                in_range_q;
    logic [BusWidth-1:0] rdata_q;

    logic [BusWidth-1:0] mem [Depth];

    logic [BusWidth-1:0] off;
    logic [BusWidth-1:0] word_off;
    logic                in_range;
    logic [IdxW-1:0]     idx;

    // The offset wraps at BusWidth bits, so addresses below the base are caught explicitly.
    assign off      = slave_add_i - BaseAddr;
    assign word_off = off >> ByteShift;
    assign in_range = (slave_add_i >= BaseAddr) && (word_off < BusWidth'(Depth));
    assign idx      = word_off[IdxW-1:0];

    always_comb begin
        slave_gnt_o = 1'b0;
        case (state_q)
            StIdle:    slave_gnt_o = slave_req_i && (GntDelay == 0);
            StGntWait: slave_gnt_o = slave_req_i && (cnt_q == '0);
            default:   slave_gnt_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            in_range_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (slave_req_i) begin
                        if (GntDelay == 0) begin
                            state_q <= StResp;
                            cnt_q   <= RespLoad;
                        end else begin
                            state_q <= StGntWait;
                            cnt_q   <= GntLoad;
                        end
                    end
                end
                StGntWait: begin
                    if (!slave_req_i) begin
                        state_q <= StIdle;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= StResp;
                        cnt_q   <= RespLoad;
                    end
                end
                StResp: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase

            // Read data is frozen at the grant edge; writes and errors return zero.
            if (slave_gnt_o) begin
                in_range_q <= in_range;
                rdata_q    <= (!slave_we_i && in_range) ? mem[idx] : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (slave_gnt_o && slave_we_i && in_range) begin
            for (int k = 0; k < NumBytes; k++) begin
                if (slave_be_i[k]) begin
                    mem[idx][8*k +: 8] <= slave_wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign slave_r_valid_o = (state_q == StResp) && (cnt_q == '0);
    assign slave_r_rdata_o = slave_r_valid_o ? rdata_q : '0;
    assign slave_err_o     = slave_r_valid_o && !in_range_q;

endmodule

// File: tb/tb_dm_sba_mem_responder.sv
// Bench for dm_sba_mem_responder: two instances (no-delay and delayed) with a vector table,
// hand-written corner sequences and a randomized run against a byte-level memory model.
module tb_dm_sba_mem_responder;

    localparam logic [31:0] Base1  = 32'h100;
    localparam int unsigned Depth1 = 16;

    logic        clk;
    logic        rst_n;
    logic        req   [2];
    logic [31:0] add   [2];
    logic        we    [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        gnt   [2];
    logic        rv    [2];
    logic [31:0] rdata [2];
    logic        err   [2];

    int n_cmp;
    int n_fail;
    bit mon_en;
    bit outst [2];

    dm_sba_mem_responder #(
        .BusWidth (32),
        .Depth    (256),
        .BaseAddr (32'h0),
        .GntDelay (0),
        .RespDelay(1)
    ) u_dut0 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .slave_req_i    (req[0]),
        .slave_add_i    (add[0]),
        .slave_we_i     (we[0]),
        .slave_wdata_i  (wdata[0]),
        .slave_be_i     (be[0]),
        .slave_gnt_o    (gnt[0]),
        .slave_r_valid_o(rv[0]),
        .slave_r_rdata_o(rdata[0]),
        .slave_err_o    (err[0])
    );

    dm_sba_mem_responder #(
        .BusWidth (32),
        .Depth    (Depth1),
        .BaseAddr (Base1),
        .GntDelay (2),
        .RespDelay(3)
    ) u_dut1 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .slave_req_i    (req[1]),
        .slave_add_i    (add[1]),
        .slave_we_i     (we[1]),
        .slave_wdata_i  (wdata[1]),
        .slave_be_i     (be[1]),
        .slave_gnt_o    (gnt[1]),
        .slave_r_valid_o(rv[1]),
        .slave_r_rdata_o(rdata[1]),
        .slave_err_o    (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gdel(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic int rdel(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Protocol monitor: one gnt per response, no orphan r_valid, quiet outputs between responses.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (!rv[d] && (rdata[d] != 32'h0 || err[d])) begin
                    n_fail++;
                    $display("FAIL idle_outputs[%0d]: rdata=%h err=%b, required 0/0", d, rdata[d],
                             err[d]);
                end
                n_cmp++;
                if ((gnt[d] && outst[d]) || (rv[d] && !outst[d])) begin
                    n_fail++;
                    $display("FAIL handshake[%0d]: gnt=%b r_valid=%b outstanding=%b", d, gnt[d],
                             rv[d], outst[d]);
                end
                if (rv[d]) outst[d] = 1'b0;
                if (gnt[d]) outst[d] = 1'b1;
                if (!rst_n) outst[d] = 1'b0;
            end
        end
    end

    task automatic wait_gnt(input int d, output int c);
        c = 0;
        forever begin
            @(negedge clk);
            if (gnt[d] || c > 40) break;
            c++;
        end
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, output logic [31:0] rd, output logic er,
                       output int gl, output int rl);
        @(posedge clk);
        #1;
        req[d] = 1'b1; we[d] = w; add[d] = a; wdata[d] = wd; be[d] = b;
        wait_gnt(d, gl);
        @(posedge clk);
        #1;
        // Scramble the bus after the grant edge so any missing latch shows up.
        req[d] = 1'b0; add[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
        we[d] = 1'($urandom);
        rl = 0; rd = 32'h0; er = 1'b0;
        if (gl <= 40) begin
            forever begin
                @(negedge clk);
                rl++;
                if (rv[d]) begin
                    rd = rdata[d];
                    er = err[d];
                    break;
                end
                if (rl > 40) break;
            end
        end
    endtask

    typedef struct {
        int          d;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  b;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    bit [7:0] ref_mem [bit [31:0]];

    initial begin
        vec_t        vt [$];
        logic [31:0] rd;
        logic        er;
        int          gl, rl, c;

        n_cmp = 0; n_fail = 0; mon_en = 1'b0;
        outst[0] = 1'b0; outst[1] = 1'b0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; add[d] = '0; we[d] = 1'b0; wdata[d] = '0; be[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_gnt[%0d]", d), 32'(gnt[d]), 32'h0);
            chk($sformatf("reset_rvalid[%0d]", d), 32'(rv[d]), 32'h0);
            chk($sformatf("reset_rdata[%0d]", d), rdata[d], 32'h0);
            chk($sformatf("reset_err[%0d]", d), 32'(err[d]), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // d, we, addr, wdata, be, expected rdata, expected err
        vt.push_back('{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vt.push_back('{0, 1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
        vt.push_back('{0, 1'b1, 32'h13,  32'h0000AB00, 4'h2, 32'h0,        1'b0});
        vt.push_back('{0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADABEF, 1'b0});
        vt.push_back('{0, 1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
        vt.push_back('{0, 1'b0, 32'h11,  32'h0,        4'h1, 32'hDEADABEF, 1'b0});
        vt.push_back('{0, 1'b1, 32'h0,   32'hAAAA5555, 4'hF, 32'h0,        1'b0});
        vt.push_back('{0, 1'b1, 32'h3FC, 32'h01020304, 4'hF, 32'h0,        1'b0});
        vt.push_back('{0, 1'b1, 32'h400, 32'h12345678, 4'hF, 32'h0,        1'b1});
        vt.push_back('{0, 1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1});
        vt.push_back('{0, 1'b0, 32'h0,   32'h0,        4'hF, 32'hAAAA5555, 1'b0});
        vt.push_back('{0, 1'b0, 32'h3FC, 32'h0,        4'hF, 32'h01020304, 1'b0});
        vt.push_back('{1, 1'b1, 32'h100, 32'h11223344, 4'hF, 32'h0,        1'b0});
        vt.push_back('{1, 1'b1, 32'h13C, 32'h55667788, 4'hF, 32'h0,        1'b0});
        vt.push_back('{1, 1'b1, 32'h140, 32'h99999999, 4'hF, 32'h0,        1'b1});
        vt.push_back('{1, 1'b0, 32'h140, 32'h0,        4'hF, 32'h0,        1'b1});
        vt.push_back('{1, 1'b1, 32'hFC,  32'h99999999, 4'hF, 32'h0,        1'b1});
        vt.push_back('{1, 1'b0, 32'hFC,  32'h0,        4'hF, 32'h0,        1'b1});
        vt.push_back('{1, 1'b0, 32'h100, 32'h0,        4'hF, 32'h11223344, 1'b0});
        vt.push_back('{1, 1'b0, 32'h13C, 32'h0,        4'hF, 32'h55667788, 1'b0});

        foreach (vt[i]) begin
            txn(vt[i].d, vt[i].w, vt[i].a, vt[i].wd, vt[i].b, rd, er, gl, rl);
            chk($sformatf("vec%0d_gnt_lat", i), 32'(gl), 32'(gdel(vt[i].d)));
            chk($sformatf("vec%0d_resp_lat", i), 32'(rl), 32'(rdel(vt[i].d)));
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_er));
        end

        // Request dropped while waiting for grant: no gnt, no response, back to idle.
        @(posedge clk);
        #1;
        req[1] = 1'b1; we[1] = 1'b0; add[1] = 32'h100; be[1] = 4'hF;
        @(negedge clk);
        chk("drop_gnt_c0", 32'(gnt[1]), 32'h0);
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("drop_gnt_c%0d", i + 1), 32'(gnt[1]), 32'h0);
            chk($sformatf("drop_rvalid_c%0d", i + 1), 32'(rv[1]), 32'h0);
        end
        txn(1, 1'b0, 32'h13C, 32'h0, 4'hF, rd, er, gl, rl);
        chk("after_drop_gnt_lat", 32'(gl), 32'd2);
        chk("after_drop_resp_lat", 32'(rl), 32'd3);
        chk("after_drop_rdata", rd, 32'h55667788);

        // Request held across four reads: grant every other cycle, response in between.
        @(posedge clk);
        #1;
        req[0] = 1'b1; we[0] = 1'b0; add[0] = 32'h10; be[0] = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("held_gnt_c%0d", i), 32'(gnt[0]), 32'((i % 2) == 0));
            chk($sformatf("held_rvalid_c%0d", i), 32'(rv[0]), 32'((i % 2) == 1));
            chk($sformatf("held_rdata_c%0d", i), rdata[0], ((i % 2) == 1) ? 32'hDEADABEF : 32'h0);
        end
        @(posedge clk);
        #1;
        req[0] = 1'b0;

        // Reset while a granted write waits for its response: response dropped, write kept.
        @(posedge clk);
        #1;
        req[1] = 1'b1; we[1] = 1'b1; add[1] = 32'h104; wdata[1] = 32'hCAFEF00D; be[1] = 4'hF;
        wait_gnt(1, c);
        chk("rst_seq_gnt_lat", 32'(c), 32'd2);
        @(posedge clk);
        #1;
        req[1] = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_seq_rvalid_in_rst", 32'(rv[1]), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst_seq_rvalid_c%0d", i), 32'(rv[1]), 32'h0);
            chk($sformatf("rst_seq_gnt_c%0d", i), 32'(gnt[1]), 32'h0);
        end
        txn(1, 1'b0, 32'h104, 32'h0, 4'h0, rd, er, gl, rl);
        chk("post_rst_gnt_lat", 32'(gl), 32'd2);
        chk("post_rst_resp_lat", 32'(rl), 32'd3);
        chk("post_rst_rdata", rd, 32'hCAFEF00D);
        chk("post_rst_err", 32'(er), 32'h0);

        // Randomized traffic on the based instance against a byte-addressed model.
        for (int i = 0; i < Depth1; i++) begin
            logic [31:0] v;
            v = $urandom;
            txn(1, 1'b1, Base1 + 32'(4 * i), v, 4'hF, rd, er, gl, rl);
            for (int k = 0; k < 4; k++) ref_mem[Base1 + 32'(4 * i + k)] = v[8*k +: 8];
        end
        for (int i = 0; i < 120; i++) begin
            logic        w;
            logic [31:0] a, v, wa, exp_rd;
            logic [3:0]  b;
            logic        inr;
            w = 1'($urandom);
            a = 32'hF0 + 32'($urandom_range(0, 32'h5F));
            v = $urandom;
            b = 4'($urandom);
            inr = (a >= Base1) && ((a - Base1) / 4 < Depth1);
            wa = Base1 + 4 * ((a - Base1) / 4);
            exp_rd = 32'h0;
            if (inr && w) begin
                for (int k = 0; k < 4; k++) if (b[k]) ref_mem[wa + 32'(k)] = v[8*k +: 8];
            end else if (inr) begin
                for (int k = 0; k < 4; k++) exp_rd[8*k +: 8] = ref_mem[wa + 32'(k)];
            end
            txn(1, w, a, v, b, rd, er, gl, rl);
            chk($sformatf("rnd%0d_gnt_lat a=%h", i, a), 32'(gl), 32'd2);
            chk($sformatf("rnd%0d_resp_lat a=%h", i, a), 32'(rl), 32'd3);
            chk($sformatf("rnd%0d_rdata a=%h we=%b", i, a, w), rd, exp_rd);
            chk($sformatf("rnd%0d_err a=%h", i, a), 32'(er), 32'(!inr));
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
